// File: rtl/rv32v_strided_mem_sequencer_if.sv
// Bundle between the pipeline/LSC side and the strided vector memory sequencer.
// The slave modport is the sequencer's view; master is the surrounding environment's view.
interface rv32v_strided_mem_sequencer_if #(
    parameter int NUM_LANES = 4,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32
);
    localparam int LW = $clog2(NUM_LANES);

    logic                        start;
    logic                        is_store;
    logic [ADDR_W-1:0]           base_addr;
    logic [ADDR_W-1:0]           stride;
    logic [1:0]                  eew;
    logic [NUM_LANES-1:0]        elem_mask;
    logic [NUM_LANES*DATA_W-1:0] store_data;
    logic                        flush;
    logic                        mem_busy;
    logic [DATA_W-1:0]           mem_rdata;

    logic                        mem_ren;
    logic                        mem_wen;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic [1:0]                  mem_load_type;
    logic                        busy;
    logic                        done;
    logic                        fault;
    logic [ADDR_W-1:0]           fault_addr;
    logic [LW-1:0]               lane_idx;
    logic [NUM_LANES-1:0]        lane_wen;
    logic [DATA_W-1:0]           lane_rdata;

    modport slave (
        input  start, is_store, base_addr, stride, eew, elem_mask, store_data,
               flush, mem_busy, mem_rdata,
        output mem_ren, mem_wen, mem_addr, mem_wdata, mem_load_type, busy, done,
               fault, fault_addr, lane_idx, lane_wen, lane_rdata
    );

    modport master (
        output start, is_store, base_addr, stride, eew, elem_mask, store_data,
               flush, mem_busy, mem_rdata,
        input  mem_ren, mem_wen, mem_addr, mem_wdata, mem_load_type, busy, done,
               fault, fault_addr, lane_idx, lane_wen, lane_rdata
    );
endinterface

// File: rtl/rv32v_strided_mem_sequencer.sv
// Serialises one vector load/store descriptor into scalar LSC accesses, one per active element.
// RV32V_SERIAL_STRIDE_EN: honour the stride port; otherwise elements are unit-stride.
//   state  | meaning
//   S_IDLE | waiting for a descriptor
//   S_REQ  | issuing the access for element lane_idx
//   S_DONE | one-cycle completion pulse
module rv32v_strided_mem_sequencer #(
    parameter int NUM_LANES = 4,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32
) (
    input  logic                           CLK,
    input  logic                           nRST,
    rv32v_strided_mem_sequencer_if.slave   bus
);
    localparam int LW = $clog2(NUM_LANES);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_e;

    state_e                      state_q;
    logic                        is_store_q;
    logic [ADDR_W-1:0]           base_q;
    logic [1:0]                  eew_q;
    logic [NUM_LANES-1:0]        mask_q;
    logic [NUM_LANES*DATA_W-1:0] sdata_q;
    logic [LW-1:0]               idx_q;
    logic [ADDR_W-1:0]           addr_q;
    logic [DATA_W-1:0]           wdata_q;
    logic [ADDR_W-1:0]           fault_addr_q;

    logic [LW-1:0]               first_idx_d;
    logic [LW-1:0]               next_idx_d;
    logic [NUM_LANES-1:0]        mask_left_d;
    logic [ADDR_W-1:0]           first_addr_d;
    logic [ADDR_W-1:0]           next_addr_d;
    logic                        accept;
    logic                        misal;
    logic                        req_ok;
    logic                        complete;

    function automatic logic [LW-1:0] lowest_set(input logic [NUM_LANES-1:0] m);
        logic [LW-1:0] r;
        r = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (m[i]) r = LW'(i);
        end
        return r;
    endfunction

    // eew=3 is illegal and handled as a word access everywhere
    function automatic logic misaligned(input logic [ADDR_W-1:0] a, input logic [1:0] ew);
        logic r;
        case (ew)
            2'd0:    r = 1'b0;
            2'd1:    r = a[0];
            default: r = |a[1:0];
        endcase
        return r;
    endfunction

    always_comb begin
        first_idx_d = lowest_set(bus.elem_mask);
        mask_left_d = mask_q & ~(NUM_LANES'(1) << idx_q);
        next_idx_d  = lowest_set(mask_left_d);
    end

`ifdef RV32V_SERIAL_STRIDE_EN
    logic [ADDR_W-1:0] stride_q;

    assign first_addr_d = bus.base_addr + ADDR_W'(first_idx_d) * bus.stride;
    assign next_addr_d  = base_q + ADDR_W'(next_idx_d) * stride_q;
`else
    function automatic logic [1:0] eff_shift(input logic [1:0] ew);
        return (ew == 2'd3) ? 2'd2 : ew;
    endfunction

    logic unused_stride;
    assign unused_stride = ^bus.stride;
    assign first_addr_d  = bus.base_addr + (ADDR_W'(first_idx_d) << eff_shift(bus.eew));
    assign next_addr_d   = base_q + (ADDR_W'(next_idx_d) << eff_shift(eew_q));
`endif

    assign accept   = (state_q == S_IDLE) && bus.start && !bus.flush;
    assign misal    = misaligned(addr_q, eew_q);
    assign req_ok   = (state_q == S_REQ) && !misal && !bus.flush;
    assign complete = req_ok && !bus.mem_busy;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q      <= S_IDLE;
            is_store_q   <= 1'b0;
            base_q       <= '0;
            eew_q        <= '0;
            mask_q       <= '0;
            sdata_q      <= '0;
            idx_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            fault_addr_q <= '0;
`ifdef RV32V_SERIAL_STRIDE_EN
            stride_q     <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        is_store_q   <= bus.is_store;
                        base_q       <= bus.base_addr;
                        eew_q        <= bus.eew;
                        mask_q       <= bus.elem_mask;
                        sdata_q      <= bus.store_data;
                        idx_q        <= first_idx_d;
                        addr_q       <= first_addr_d;
                        wdata_q      <= bus.store_data[int'(first_idx_d)*DATA_W +: DATA_W];
                        fault_addr_q <= '0;
`ifdef RV32V_SERIAL_STRIDE_EN
                        stride_q     <= bus.stride;
`endif
                        state_q      <= (bus.elem_mask == '0) ? S_DONE : S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.flush) begin
                        state_q <= S_IDLE;
                    end else if (misal) begin
                        fault_addr_q <= addr_q;
                        state_q      <= S_IDLE;
                    end else if (!bus.mem_busy) begin
                        mask_q <= mask_left_d;
                        if (mask_left_d == '0) begin
                            state_q <= S_DONE;
                        end else begin
                            idx_q   <= next_idx_d;
                            addr_q  <= next_addr_d;
                            wdata_q <= sdata_q[int'(next_idx_d)*DATA_W +: DATA_W];
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_ren       = req_ok && !is_store_q;
    assign bus.mem_wen       = req_ok && is_store_q;
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.mem_load_type = eew_q;
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.done          = (state_q == S_DONE) && !bus.flush;
    assign bus.fault         = (state_q == S_REQ) && misal && !bus.flush;
    assign bus.fault_addr    = fault_addr_q;
    assign bus.lane_idx      = idx_q;
    assign bus.lane_wen      = (complete && !is_store_q) ? (NUM_LANES'(1) << idx_q) : '0;
    assign bus.lane_rdata    = bus.mem_rdata;
endmodule

// File: tb/tb_rv32v_strided_mem_sequencer.sv
// Self-checking bench for rv32v_strided_mem_sequencer: directed scenarios plus a randomized
// descriptor stream compared against an element-list reference model.
module tb_rv32v_strided_mem_sequencer;
    localparam int NL = 4;
    localparam int DW = 32;
    localparam int AW = 32;

    logic clk;
    logic nrst;
    int   nchk;
    int   npass;

    rv32v_strided_mem_sequencer_if #(.NUM_LANES(NL), .DATA_W(DW), .ADDR_W(AW)) bus ();

    rv32v_strided_mem_sequencer #(.NUM_LANES(NL), .DATA_W(DW), .ADDR_W(AW)) dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, exp finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_desc(input logic st, input logic [31:0] b, input logic [31:0] s,
                              input logic [1:0] w, input logic [NL-1:0] m,
                              input logic [NL*DW-1:0] sd);
        bus.start      = 1'b1;
        bus.is_store   = st;
        bus.base_addr  = b;
        bus.stride     = s;
        bus.eew        = w;
        bus.elem_mask  = m;
        bus.store_data = sd;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        bus.start = 0; bus.is_store = 0; bus.base_addr = 0; bus.stride = 0; bus.eew = 0;
        bus.elem_mask = 0; bus.store_data = 0; bus.flush = 0; bus.mem_busy = 0; bus.mem_rdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nchk++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.fault !== 1'b0) $display("FAIL reset_flags: got busy=%b done=%b fault=%b exp 0 0 0", bus.busy, bus.done, bus.fault); else npass++;
        nchk++; if (bus.mem_ren !== 1'b0 || bus.mem_wen !== 1'b0 || bus.lane_wen !== '0) $display("FAIL reset_strobes: got ren=%b wen=%b lane_wen=%b exp 0", bus.mem_ren, bus.mem_wen, bus.lane_wen); else npass++;
        nchk++; if (bus.mem_addr !== '0 || bus.mem_wdata !== '0 || bus.fault_addr !== '0 || bus.lane_idx !== '0) $display("FAIL reset_regs: got addr=%h wdata=%h faddr=%h idx=%0d exp 0", bus.mem_addr, bus.mem_wdata, bus.fault_addr, bus.lane_idx); else npass++;
        tick();
        nrst = 1'b1;
        // a reset in mid-sequence overrides everything
        drive_desc(1'b0, 32'h0000_8000, 32'd4, 2'd2, 4'b1111, '0);
        tick();
        bus.start = 1'b0;
        @(negedge clk);
        nchk++; if (bus.busy !== 1'b1) $display("FAIL reset_pre_busy: got %b exp 1", bus.busy); else npass++;
        tick();
        nrst = 1'b0;
        bus.flush = 1'b1;
        tick();
        nrst = 1'b1;
        bus.flush = 1'b0;
        @(negedge clk);
        nchk++; if (bus.busy !== 1'b0 || bus.mem_addr !== '0 || bus.lane_idx !== '0 || bus.mem_ren !== 1'b0) $display("FAIL reset_mid: got busy=%b addr=%h idx=%0d ren=%b exp 0", bus.busy, bus.mem_addr, bus.lane_idx, bus.mem_ren); else npass++;
        tick();
    endtask

    task automatic test_unit_load();
        logic [31:0] rd;
        drive_desc(1'b0, 32'h0000_1000, 32'd4, 2'd2, 4'b1111, '0);
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            rd = $urandom;
            bus.mem_rdata = rd;
            @(negedge clk);
            nchk++; if (bus.mem_ren !== 1'b1 || bus.mem_wen !== 1'b0) $display("FAIL unit_req c%0d: got ren=%b wen=%b exp 1 0", c, bus.mem_ren, bus.mem_wen); else npass++;
            nchk++; if (bus.mem_addr !== 32'h1000 + 32'(4*(c-1))) $display("FAIL unit_addr c%0d: got %h exp %h", c, bus.mem_addr, 32'h1000 + 32'(4*(c-1))); else npass++;
            nchk++; if (bus.lane_wen !== NL'(1 << (c-1)) || bus.lane_rdata !== rd) $display("FAIL unit_lane c%0d: got wen=%b data=%h exp %b %h", c, bus.lane_wen, bus.lane_rdata, NL'(1 << (c-1)), rd); else npass++;
            nchk++; if (bus.done !== 1'b0 || bus.mem_load_type !== 2'd2) $display("FAIL unit_mid c%0d: got done=%b type=%0d exp 0 2", c, bus.done, bus.mem_load_type); else npass++;
            tick();
        end
        @(negedge clk);
        nchk++; if (bus.done !== 1'b1 || bus.mem_ren !== 1'b0) $display("FAIL unit_done: got done=%b ren=%b exp 1 0", bus.done, bus.mem_ren); else npass++;
        tick();
        @(negedge clk);
        nchk++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL unit_idle: got busy=%b done=%b exp 0 0", bus.busy, bus.done); else npass++;
    endtask

    task automatic test_strided_store();
        logic [NL*DW-1:0] sd;
        logic [31:0] exp_a [2];
        int exp_l [2];
        sd = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
`ifdef RV32V_SERIAL_STRIDE_EN
        exp_a[0] = 32'h2038; exp_a[1] = 32'h2028;
`else
        exp_a[0] = 32'h2044; exp_a[1] = 32'h204C;
`endif
        exp_l[0] = 1; exp_l[1] = 3;
        drive_desc(1'b1, 32'h0000_2040, 32'hFFFF_FFF8, 2'd2, 4'b1010, sd);
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            nchk++; if (bus.mem_wen !== 1'b1 || bus.mem_ren !== 1'b0 || bus.lane_wen !== '0) $display("FAIL store_req k%0d: got wen=%b ren=%b lane_wen=%b exp 1 0 0", k, bus.mem_wen, bus.mem_ren, bus.lane_wen); else npass++;
            nchk++; if (bus.mem_addr !== exp_a[k] || bus.lane_idx !== 2'(exp_l[k])) $display("FAIL store_addr k%0d: got %h idx %0d exp %h idx %0d", k, bus.mem_addr, bus.lane_idx, exp_a[k], exp_l[k]); else npass++;
            nchk++; if (bus.mem_wdata !== sd[exp_l[k]*DW +: DW]) $display("FAIL store_data k%0d: got %h exp %h", k, bus.mem_wdata, sd[exp_l[k]*DW +: DW]); else npass++;
            tick();
        end
        @(negedge clk);
        nchk++; if (bus.done !== 1'b1 || bus.mem_wen !== 1'b0) $display("FAIL store_done: got done=%b wen=%b exp 1 0", bus.done, bus.mem_wen); else npass++;
        tick();
    endtask

    task automatic test_wait_states();
        drive_desc(1'b0, 32'h0000_7000, 32'd4, 2'd2, 4'b0001, '0);
        tick();
        bus.start = 1'b0;
        bus.mem_busy = 1'b1;
        bus.mem_rdata = 32'h1234_5678;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            nchk++; if (bus.mem_ren !== 1'b1 || bus.mem_addr !== 32'h7000 || bus.lane_wen !== '0) $display("FAIL wait_hold c%0d: got ren=%b addr=%h lane_wen=%b exp 1 7000 0", c, bus.mem_ren, bus.mem_addr, bus.lane_wen); else npass++;
            tick();
        end
        bus.mem_busy = 1'b0;
        @(negedge clk);
        nchk++; if (bus.lane_wen !== 4'b0001 || bus.lane_rdata !== 32'h1234_5678) $display("FAIL wait_complete: got wen=%b data=%h exp 0001 12345678", bus.lane_wen, bus.lane_rdata); else npass++;
        tick();
        @(negedge clk);
        nchk++; if (bus.done !== 1'b1) $display("FAIL wait_done: got %b exp 1", bus.done); else npass++;
        tick();
    endtask

    task automatic test_zero_mask();
        drive_desc(1'b0, 32'h0000_9000, 32'd4, 2'd2, 4'b0000, '0);
        tick();
        bus.start = 1'b0;
        @(negedge clk);
        nchk++; if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.mem_ren !== 1'b0) $display("FAIL zero_c1: got done=%b busy=%b ren=%b exp 1 1 0", bus.done, bus.busy, bus.mem_ren); else npass++;
        tick();
        @(negedge clk);
        nchk++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) $display("FAIL zero_c2: got done=%b busy=%b exp 0 0", bus.done, bus.busy); else npass++;
    endtask

    task automatic test_misaligned();
        drive_desc(1'b0, 32'h0000_3001, 32'd2, 2'd1, 4'b0001, '0);
        tick();
        bus.start = 1'b0;
        @(negedge clk);
        nchk++; if (bus.fault !== 1'b1 || bus.mem_ren !== 1'b0 || bus.done !== 1'b0) $display("FAIL misal_c1: got fault=%b ren=%b done=%b exp 1 0 0", bus.fault, bus.mem_ren, bus.done); else npass++;
        tick();
        @(negedge clk);
        nchk++; if (bus.busy !== 1'b0 || bus.fault !== 1'b0 || bus.done !== 1'b0) $display("FAIL misal_c2: got busy=%b fault=%b done=%b exp 0 0 0", bus.busy, bus.fault, bus.done); else npass++;
        nchk++; if (bus.fault_addr !== 32'h3001) $display("FAIL misal_faddr: got %h exp 00003001", bus.fault_addr); else npass++;
        tick();
        @(negedge clk);
        nchk++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) $display("FAIL misal_c3: got done=%b busy=%b exp 0 0", bus.done, bus.busy); else npass++;
    endtask

    task automatic test_flush();
        int wen_cnt;
        wen_cnt = 0;
        // flush beats start while idle
        drive_desc(1'b0, 32'h0000_5000, 32'd4, 2'd2, 4'b1111, '0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        nchk++; if (bus.busy !== 1'b0) $display("FAIL flush_beats_start: got busy=%b exp 0", bus.busy); else npass++;
        drive_desc(1'b0, 32'h0000_5000, 32'd4, 2'd2, 4'b1111, '0);
        tick();
        bus.start = 1'b0;
        @(negedge clk);
        if (bus.lane_wen !== '0) wen_cnt++;
        tick();
        bus.flush = 1'b1;
        @(negedge clk);
        if (bus.lane_wen !== '0) wen_cnt++;
        nchk++; if (bus.mem_ren !== 1'b0 || bus.lane_wen !== '0 || bus.done !== 1'b0 || bus.fault !== 1'b0) $display("FAIL flush_c2: got ren=%b lane_wen=%b done=%b fault=%b exp 0", bus.mem_ren, bus.lane_wen, bus.done, bus.fault); else npass++;
        nchk++; if (wen_cnt != 1) $display("FAIL flush_wen_count: got %0d exp 1", wen_cnt); else npass++;
        tick();
        bus.flush = 1'b0;
        drive_desc(1'b0, 32'h0000_6000, 32'd4, 2'd2, 4'b0010, '0);
        @(negedge clk);
        nchk++; if (bus.busy !== 1'b0) $display("FAIL flush_c3_busy: got %b exp 0", bus.busy); else npass++;
        tick();
        bus.start = 1'b0;
        @(negedge clk);
        nchk++; if (bus.mem_ren !== 1'b1 || bus.mem_addr !== 32'h6004 || bus.lane_wen !== 4'b0010) $display("FAIL flush_restart: got ren=%b addr=%h wen=%b exp 1 6004 0010", bus.mem_ren, bus.mem_addr, bus.lane_wen); else npass++;
        tick();
        @(negedge clk);
        nchk++; if (bus.done !== 1'b1) $display("FAIL flush_restart_done: got %b exp 1", bus.done); else npass++;
        tick();
    endtask

    task automatic test_random(input int iters);
        for (int it = 0; it < iters; it++) begin
            logic st;
            logic [31:0] b, s, a, faddr, rd;
            logic [1:0] w;
            logic [NL-1:0] m;
            logic [NL*DW-1:0] sd;
            int ebytes, sv, waits;
            bit fault_exp, got;
            int lanes[$];
            logic [31:0] addrs[$];
            lanes.delete();
            addrs.delete();
            st = 1'($urandom_range(0, 1));
            w  = 2'($urandom_range(0, 3));
            m  = NL'($urandom);
            sd = {$urandom, $urandom, $urandom, $urandom};
            ebytes = (w == 2'd3) ? 4 : (1 << w);
            b = 32'h4000 + 32'($urandom_range(0, 255) * ebytes);
            if ($urandom_range(0, 5) == 0) b = b + 32'($urandom_range(1, 3));
            sv = int'($urandom_range(0, 8)) - 4;
            s = 32'(sv * ebytes);
            if ($urandom_range(0, 7) == 0) s = s + 32'd1;
            fault_exp = 1'b0;
            faddr = '0;
            for (int i = 0; i < NL; i++) begin
                if (m[i] && !fault_exp) begin
`ifdef RV32V_SERIAL_STRIDE_EN
                    a = b + 32'(i) * s;
`else
                    a = b + 32'(i * ebytes);
`endif
                    if ((a % 32'(ebytes)) != 0) begin
                        fault_exp = 1'b1;
                        faddr = a;
                    end else begin
                        lanes.push_back(i);
                        addrs.push_back(a);
                    end
                end
            end
            drive_desc(st, b, s, w, m, sd);
            tick();
            bus.start = 1'b0;
            for (int k = 0; k < lanes.size(); k++) begin
                got = 1'b0;
                waits = 0;
                while (!got) begin
                    bus.mem_busy = (waits < 6) && ($urandom_range(0, 3) == 0);
                    rd = $urandom;
                    bus.mem_rdata = rd;
                    @(negedge clk);
                    nchk++; if (bus.mem_ren !== !st || bus.mem_wen !== st || bus.mem_addr !== addrs[k] || bus.lane_idx !== 2'(lanes[k])) $display("FAIL rand_req it%0d k%0d: got ren=%b wen=%b addr=%h idx=%0d exp ren=%b addr=%h idx=%0d", it, k, bus.mem_ren, bus.mem_wen, bus.mem_addr, bus.lane_idx, !st, addrs[k], lanes[k]); else npass++;
                    nchk++; if (bus.lane_wen !== ((st || bus.mem_busy) ? NL'(0) : NL'(1 << lanes[k]))) $display("FAIL rand_lane_wen it%0d k%0d: got %b busy=%b", it, k, bus.lane_wen, bus.mem_busy); else npass++;
                    if (st) begin
                        nchk++; if (bus.mem_wdata !== sd[lanes[k]*DW +: DW]) $display("FAIL rand_wdata it%0d k%0d: got %h exp %h", it, k, bus.mem_wdata, sd[lanes[k]*DW +: DW]); else npass++;
                    end else begin
                        nchk++; if (bus.lane_rdata !== rd) $display("FAIL rand_rdata it%0d k%0d: got %h exp %h", it, k, bus.lane_rdata, rd); else npass++;
                    end
                    got = !bus.mem_busy;
                    waits++;
                    tick();
                end
            end
            bus.mem_busy = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (fault_exp) begin
                nchk++; if (bus.fault !== 1'b1 || bus.done !== 1'b0 || bus.mem_ren !== 1'b0 || bus.mem_wen !== 1'b0 || bus.mem_addr !== faddr) $display("FAIL rand_fault it%0d: got fault=%b done=%b ren=%b wen=%b addr=%h exp 1 0 0 0 %h", it, bus.fault, bus.done, bus.mem_ren, bus.mem_wen, bus.mem_addr, faddr); else npass++;
            end else begin
                nchk++; if (bus.done !== 1'b1 || bus.fault !== 1'b0 || bus.mem_ren !== 1'b0 || bus.mem_wen !== 1'b0) $display("FAIL rand_done it%0d: got done=%b fault=%b ren=%b wen=%b exp 1 0 0 0", it, bus.done, bus.fault, bus.mem_ren, bus.mem_wen); else npass++;
            end
            tick();
            bus.mem_busy = 1'b0;
            @(negedge clk);
            nchk++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.fault !== 1'b0) $display("FAIL rand_idle it%0d: got busy=%b done=%b fault=%b exp 0", it, bus.busy, bus.done, bus.fault); else npass++;
            if (fault_exp) begin
                nchk++; if (bus.fault_addr !== faddr) $display("FAIL rand_faddr it%0d: got %h exp %h", it, bus.fault_addr, faddr); else npass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        // a start during DONE is dropped; the one in the following idle cycle is taken
        drive_desc(1'b0, 32'h0000_A000, 32'd4, 2'd2, 4'b0001, '0);
        tick();
        @(negedge clk);
        nchk++; if (bus.lane_wen !== 4'b0001) $display("FAIL b2b_first: got %b exp 0001", bus.lane_wen); else npass++;
        drive_desc(1'b0, 32'h0000_B000, 32'd4, 2'd2, 4'b0100, '0);
        tick();
        @(negedge clk);
        nchk++; if (bus.done !== 1'b1) $display("FAIL b2b_done: got %b exp 1", bus.done); else npass++;
        tick();
        bus.start = 1'b0;
        @(negedge clk);
        nchk++; if (bus.busy !== 1'b0) $display("FAIL b2b_idle: got %b exp 0", bus.busy); else npass++;
        drive_desc(1'b0, 32'h0000_C000, 32'd4, 2'd2, 4'b0100, '0);
        tick();
        bus.start = 1'b0;
        @(negedge clk);
        nchk++; if (bus.mem_addr !== 32'hC008 || bus.lane_wen !== 4'b0100) $display("FAIL b2b_second: got addr=%h wen=%b exp C008 0100", bus.mem_addr, bus.lane_wen); else npass++;
        tick();
        tick();
    endtask

    initial begin
        nchk  = 0;
        npass = 0;
        test_reset();
        test_unit_load();
        test_strided_store();
        test_wait_states();
        test_zero_mask();
        test_misaligned();
        test_flush();
        test_back_to_back();
        test_random(60);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule

// File: doc/rv32v_strided_mem_sequencer.md
# rv32v_strided_mem_sequencer

Parametrised successor to the fixed 4-lane vector memory serializer in the stage4 memory stage. It accepts one vector load/store descriptor and issues one scalar access per active element to the load-store controller. Supported descriptors: base address, byte stride, element width and element mask. Masked-off elements are skipped in zero cycles. For loads it produces one-hot lane write strobes with the returned data, and the sequence can be aborted by a pipeline flush.

## Interface
- NUM_LANES, 4, element slots per descriptor (power of two, 2..16)
- DATA_W, 32, element/bus data width
- ADDR_W, 32, address width
- CLK  in  1  clock
- nRST  in  1  reset, synchronous, active-low
- start  in  1  descriptor valid; accepted only in IDLE
- is_store  in  1  1 = store, 0 = load
- base_addr  in  ADDR_W  address of element 0
- stride  in  ADDR_W  signed byte stride, two's complement
- eew  in  2  element width: 0 = byte, 1 = half, 2 = word; 3 is illegal and treated as word
- elem_mask  in  NUM_LANES  1 = element active
- store_data  in  NUM_LANES*DATA_W  element i in bits [i*DATA_W +: DATA_W]
- flush  in  1  abort current sequence
- mem_busy  in  1  LSC busy; a request completes in a cycle where it is asserted and mem_busy=0
- mem_rdata  in  DATA_W  extended load data from LSC, valid on completion
- mem_ren / mem_wen  out  1 each  request strobes
- mem_addr  out  ADDR_W  element address
- mem_wdata  out  DATA_W  element store data, low-aligned
- mem_load_type  out  2  equals captured eew
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- fault  out  1  one-cycle misaligned-element pulse
- fault_addr  out  ADDR_W  offending address, held until next start
- lane_idx  out  $clog2(NUM_LANES)  current element index
- lane_wen  out  NUM_LANES  one-hot load-return strobe
- lane_rdata  out  DATA_W  equals mem_rdata

## Operation
- States: IDLE, REQ, DONE.
- IDLE, start=1, flush=0: capture is_store, base, stride, eew, mask and store_data.
  - Captured mask == 0: go to DONE.
  - Otherwise: lane_idx = lowest set mask bit; go to REQ.
- REQ:
  - Address: mem_addr = base + lane_idx*eff_stride, truncated mod 2^ADDR_W.
  - eff_stride = stride with RV32V_SERIAL_STRIDE_EN defined; otherwise 1<<eew.
  - Request: mem_ren = !is_store, mem_wen = is_store.
  - Store data: mem_wdata = captured store_data[lane_idx].
- Alignment check: mem_addr must be aligned to 1<<eew.
  - On misalignment, no request is driven in that cycle.
  - fault pulses and fault_addr is latched; go to IDLE with no done.
  - Elements already completed stay completed.
- Completion (request asserted and mem_busy=0):
  - Load: lane_wen[lane_idx]=1 in the same cycle.
  - Clear the mask bit, then advance lane_idx to the next set bit (priority encode, lowest first).
  - If no set bit remains, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- flush=1 in any state:
  - mem_ren, mem_wen and lane_wen are forced to 0 in that cycle.
  - Next state is IDLE; no done and no fault.
  - flush beats start in the same cycle.
- start in REQ or DONE is ignored; the descriptor is not queued.
- Outputs are held stable while mem_busy=1.
- Reset values: state IDLE, all strobes 0, lane_idx 0, mem_addr 0, mem_wdata 0, fault_addr 0, busy 0.

## Timing
- Cycle 0: start sampled. Cycle 1: first request is visible. Requests and lane_wen are registered-state decodes; lane_wen is combinational with mem_busy.
- With a zero-wait bus and k active elements: one element per cycle, done in cycle k+1.
- Zero mask: done in cycle 1.
- Wait states extend the current element only.
- Back-to-back: a new start is accepted in the cycle after done (IDLE).
- nRST low at any edge returns to the reset values at that edge; it overrides flush and start.

## Configuration
- RV32V_SERIAL_STRIDE_EN defined: stride is used as given; negative and zero strides are legal.
- Not defined: the stride port is ignored and accesses are unit-stride (stride = 1<<eew). The address adder uses a shift instead of a multiplier.

## Test plan
- Load, NUM_LANES=4, base=0x1000, eew=2, mask=4'b1111, mem_busy=0 -> addresses 0x1000/04/08/0C in cycles 1-4; lane_wen 0001, 0010, 0100, 1000; done in cycle 5.
- Store, mask=4'b1010, stride=-8 (STRIDE_EN), base=0x2040 -> only lane 1 @0x2038 and lane 3 @0x2028 are written, with store_data[1] and store_data[3]; done in cycle 3.
- Load, mask=4'b0001, mem_busy high for 3 cycles -> request held stable with mem_addr unchanged; lane_wen=0001 in cycle 4; done in cycle 5.
- mask=0 -> no request; done in cycle 1; busy high for exactly 1 cycle.
- eew=1, base=0x3001 -> no request; fault in cycle 1; fault_addr=0x3001; no done.
- flush in cycle 2 of a 4-element load -> one lane_wen only; busy=0 in cycle 3; a new start in cycle 3 is accepted normally.
